// File: rtl/ultra_pkg.sv
// ultra_pkg
// Shared definitions for the HC-SR04 front end and the downstream distance
// stage: FSM state encoding, default timing constants at 50 MHz, and the
// echo-width-per-centimetre constants used for threshold comparison.
package ultra_pkg;

    typedef enum logic [1:0] {
        TRIG      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

    // Default timing at 50 MHz.
    localparam int unsigned TRIG_CYCLES_DEF   = 500;        // 10 us trigger pulse
    localparam int unsigned PERIOD_CYCLES_DEF = 3_000_000;  // 60 ms measurement period
    localparam int unsigned WAIT_MAX_DEF      = 50_000;     // 1 ms max wait for echo rise
    localparam int unsigned CNT_W_DEF         = 20;         // echo width counter bits

    // Echo high time per centimetre of distance, and for 5 cm.
    localparam int unsigned CYCLES_PER_CM     = 2950;
    localparam int unsigned CYCLES_5CM        = 14750;

endpackage

// File: rtl/echo_sync.sv
// echo_sync
// Two-flop synchronizer for the asynchronous sensor echo line, followed by a
// previous-value register used for rising-edge detection.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   echo      in  raw echo, asynchronous to clk
//   echo_s    out synchronized echo (2 cycles behind echo)
//   echo_rise out echo_s is 1 now and was 0 the previous cycle
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic echo_s,
    output logic echo_rise
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            echo_s <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= echo;
            echo_s <= meta;
            prev   <= echo_s;
        end
    end

    // prev tracks echo_s in every state, so a line already high when the FSM
    // starts looking for a rise never looks like an edge.
    assign echo_rise = echo_s & ~prev;

endmodule

// File: rtl/ultra_ranger.sv
// ultra_ranger
// HC-SR04 front end: fires a periodic trigger, synchronizes echo, measures the
// echo high time in clock cycles and holds the last result for the downstream
// distance stage.
// Ports:
//   clk         in  system clock (50 MHz)
//   rst         in  synchronous active-high reset
//   echo        in  raw sensor echo, asynchronous
//   trig        out registered sensor trigger
//   echo_s      out synchronized echo
//   contador2   out last completed echo width in cycles, held
//   count_valid out one-cycle strobe when contador2/timeout update
//   timeout     out 1 = no echo seen, or echo width saturated
//
// state     | meaning
// ----------+-------------------------------------------------------------
// TRIG      | trig high; leaves after TRIG_CYCLES cycles
// WAIT_RISE | waiting for a clean echo_s rising edge, bounded by WAIT_MAX
// MEASURE   | counting echo_s high cycles, saturating at 2^CNT_W-1
// HOLDOFF   | result published; idle until the period counter expires
module ultra_ranger
    import ultra_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES   = TRIG_CYCLES_DEF,
    parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int unsigned WAIT_MAX      = WAIT_MAX_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             echo,
    output logic             trig,
    output logic             echo_s,
    output logic [CNT_W-1:0] contador2,
    output logic             count_valid,
    output logic             timeout
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int WW = $clog2(WAIT_MAX + 1);

    localparam logic [PW-1:0]    TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0]    PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [WW-1:0]    WAIT_LAST   = WW'(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state;
    logic [PW-1:0]    period_cnt;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic             echo_rise;

    echo_sync u_echo_sync (
        .clk       (clk),
        .rst       (rst),
        .echo      (echo),
        .echo_s    (echo_s),
        .echo_rise (echo_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TRIG;
            trig        <= 1'b0;
            period_cnt  <= '0;
            wait_cnt    <= '0;
            width_cnt   <= '0;
            contador2   <= '0;
            count_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            trig        <= 1'b0;
            // period_cnt holds the number of edges since trig was first
            // registered high in this period.
            period_cnt  <= period_cnt + PW'(1);

            case (state)
                TRIG: begin
                    trig <= 1'b1;
                    if (period_cnt == TRIG_LAST) begin
                        state    <= WAIT_RISE;
                        wait_cnt <= '0;
                    end
                end

                WAIT_RISE: begin
                    if (echo_rise) begin
                        state     <= MEASURE;
                        width_cnt <= CNT_W'(1);
                    end else if (wait_cnt == WAIT_LAST) begin
                        contador2   <= '0;
                        timeout     <= 1'b1;
                        count_valid <= 1'b1;
                        state       <= HOLDOFF;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end

                MEASURE: begin
                    if (!echo_s) begin
                        contador2   <= width_cnt;
                        timeout     <= 1'b0;
                        count_valid <= 1'b1;
                        state       <= HOLDOFF;
                    end else if (width_cnt == CNT_MAX) begin
                        // Still high at full scale: report saturation rather
                        // than wrap.
                        contador2   <= CNT_MAX;
                        timeout     <= 1'b1;
                        count_valid <= 1'b1;
                        state       <= HOLDOFF;
                    end else begin
                        width_cnt <= width_cnt + CNT_W'(1);
                    end
                end

                HOLDOFF: begin
                    if (period_cnt == PERIOD_LAST) begin
                        state      <= TRIG;
                        period_cnt <= '0;
                    end
                end

                default: begin
                    state      <= TRIG;
                    period_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultra_ranger.sv
// tb_ultra_ranger
// Self-checking bench for ultra_ranger with scaled-down timing parameters.
// Expected strobe results are queued when echo stimulus is driven and are
// compared by a monitor whenever count_valid fires.
module tb_ultra_ranger;

    localparam int P_TRIG   = 10;
    localparam int P_PERIOD = 600;
    localparam int P_WAIT   = 100;
    localparam int P_CNT_W  = 8;
    localparam int MAXV     = (1 << P_CNT_W) - 1;

    // Worst-case trigger + wait + saturated echo must fit in one period.
    if (P_TRIG + P_WAIT + MAXV >= P_PERIOD) begin : g_bad_params
        $fatal(1, "illegal parameter set: trigger + wait + saturation exceeds period");
    end

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               echo = 1'b0;
    logic               trig;
    logic               echo_s;
    logic [P_CNT_W-1:0] contador2;
    logic               count_valid;
    logic               timeout;

    ultra_ranger #(
        .TRIG_CYCLES   (P_TRIG),
        .PERIOD_CYCLES (P_PERIOD),
        .WAIT_MAX      (P_WAIT),
        .CNT_W         (P_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .echo        (echo),
        .trig        (trig),
        .echo_s      (echo_s),
        .contador2   (contador2),
        .count_valid (count_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [P_CNT_W-1:0] count;
        logic               to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cv_seen  = 0;
    int   t_rise   = 0;

    // Scoreboard monitor: every strobe must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && count_valid === 1'b1) begin
            exp_t e;
            cv_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: count_valid at cycle %0d with contador2=%0d timeout=%0b, none expected",
                         cyc, contador2, timeout);
            end else begin
                e = exp_q.pop_front();
                if (contador2 !== e.count || timeout !== e.to) begin
                    n_fail++;
                    $display("FAIL strobe_value: cycle %0d got contador2=%0d timeout=%0b, expected contador2=%0d timeout=%0b",
                             cyc, contador2, timeout, e.count, e.to);
                end
            end
        end
    end

    task automatic push_exp(input int c, input logic to);
        exp_t e;
        e.count = P_CNT_W'(c);
        e.to    = to;
        exp_q.push_back(e);
    endtask

    task automatic wait_trig_fall();
        bit got = 0;
        for (int i = 0; i < P_TRIG + 5 && !got; i++) begin
            @(negedge clk);
            if (trig === 1'b0) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL trig_fall: trig still high after %0d cycles, expected fall after %0d", P_TRIG + 5, P_TRIG);
        end else if (cyc - t_rise != P_TRIG) begin
            n_fail++;
            $display("FAIL trig_width: trig high %0d cycles, expected %0d", cyc - t_rise, P_TRIG);
        end
    endtask

    task automatic wait_trig_rise(input bit check_period);
        bit got = 0;
        for (int i = 0; i < P_PERIOD + 20 && !got; i++) begin
            @(negedge clk);
            if (trig === 1'b1) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL trig_rise: no trigger within %0d cycles, expected one every %0d", P_PERIOD + 20, P_PERIOD);
        end else if (check_period && cyc - t_rise != P_PERIOD) begin
            n_fail++;
            $display("FAIL trig_period: trigger spacing %0d cycles, expected %0d", cyc - t_rise, P_PERIOD);
        end
        t_rise = cyc;
    endtask

    task automatic wait_cv(output int at, output bit ok);
        ok = 0;
        at = 0;
        for (int i = 0; i < P_PERIOD && !ok; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1) begin
                ok = 1;
                at = cyc;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cv: no count_valid within %0d cycles, expected a strobe", P_PERIOD);
        end
    endtask

    task automatic check_latency(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: strobe %0d cycles after reference, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        echo = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %0b expected 0", trig); end
        n_checks++;
        if (echo_s !== 1'b0) begin n_fail++; $display("FAIL reset_echo_s: got %0b expected 0", echo_s); end
        n_checks++;
        if (contador2 !== '0) begin n_fail++; $display("FAIL reset_contador2: got %0d expected 0", contador2); end
        n_checks++;
        if (count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_count_valid: got %0b expected 0", count_valid); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (trig !== 1'b1) begin n_fail++; $display("FAIL reset_release_trig: got %0b expected 1 on first edge", trig); end
        t_rise = cyc;
    endtask

    task automatic test_no_echo();
        int at;
        bit ok;
        push_exp(0, 1'b1);
        wait_trig_fall();
        wait_cv(at, ok);
        if (ok) check_latency("no_echo_timeout", at - t_rise, P_TRIG + P_WAIT);
        wait_trig_rise(1'b1);
    endtask

    task automatic test_echo_pulse();
        int at;
        int f;
        bit ok;
        wait_trig_fall();
        repeat (20) @(negedge clk);
        push_exp(50, 1'b0);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        echo = 1'b0;
        f = cyc;
        wait_cv(at, ok);
        if (ok) check_latency("pulse_latency", at - f, 3);
        wait_trig_rise(1'b1);
        n_checks++;
        if (contador2 !== P_CNT_W'(50) || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_hold: got contador2=%0d timeout=%0b, expected 50 and 0", contador2, timeout);
        end
    endtask

    task automatic test_saturation();
        int   c0;
        int   sat_at = -1;
        logic es_at  = 1'b0;
        int   cv_before;
        wait_trig_fall();
        repeat (5) @(negedge clk);
        push_exp(MAXV, 1'b1);
        echo = 1'b1;
        c0   = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (count_valid === 1'b1 && sat_at < 0) begin
                sat_at = cyc;
                es_at  = echo_s;
            end
        end
        echo = 1'b0;
        cv_before = cv_seen;
        check_latency("sat_latency", sat_at - c0, 3 + MAXV);
        n_checks++;
        if (es_at !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_echo_high: echo_s at saturation strobe %0b, expected 1", es_at);
        end
        wait_trig_rise(1'b1);
        n_checks++;
        if (cv_seen != cv_before) begin
            n_fail++;
            $display("FAIL sat_second_strobe: %0d strobes after echo fall, expected 0", cv_seen - cv_before);
        end
        n_checks++;
        if (contador2 !== P_CNT_W'(MAXV) || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got contador2=%0d timeout=%0b, expected %0d and 1", contador2, timeout, MAXV);
        end
    endtask

    task automatic test_echo_high_at_entry();
        int at;
        int f;
        bit ok;
        echo = 1'b1;
        wait_trig_fall();
        repeat (10) @(negedge clk);
        echo = 1'b0;
        repeat (10) @(negedge clk);
        push_exp(30, 1'b0);
        echo = 1'b1;
        repeat (30) @(negedge clk);
        echo = 1'b0;
        f = cyc;
        wait_cv(at, ok);
        if (ok) check_latency("entry_high_latency", at - f, 3);
        wait_trig_rise(1'b1);
        n_checks++;
        if (contador2 !== P_CNT_W'(30)) begin
            n_fail++;
            $display("FAIL entry_high_value: got contador2=%0d, expected 30", contador2);
        end
    endtask

    task automatic test_reset_mid_measure();
        int at;
        bit ok;
        wait_trig_fall();
        repeat (5) @(negedge clk);
        echo = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (trig !== 1'b0) begin n_fail++; $display("FAIL midrst_trig: got %0b expected 0", trig); end
        n_checks++;
        if (contador2 !== '0) begin n_fail++; $display("FAIL midrst_contador2: got %0d expected 0", contador2); end
        n_checks++;
        if (count_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_count_valid: got %0b expected 0", count_valid); end
        n_checks++;
        if (echo_s !== 1'b0) begin n_fail++; $display("FAIL midrst_echo_s: got %0b expected 0", echo_s); end
        push_exp(0, 1'b1);
        rst  = 1'b0;
        echo = 1'b0;
        @(negedge clk);
        n_checks++;
        if (trig !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: trig %0b on first edge after release, expected 1", trig); end
        t_rise = cyc;
        wait_trig_fall();
        wait_cv(at, ok);
        if (ok) check_latency("midrst_timeout", at - t_rise, P_TRIG + P_WAIT);
        wait_trig_rise(1'b1);
    endtask

    task automatic test_short_pulse();
        int at;
        int f;
        bit ok;
        wait_trig_fall();
        repeat (8) @(negedge clk);
        push_exp(1, 1'b0);
        echo = 1'b1;
        @(negedge clk);
        echo = 1'b0;
        f = cyc;
        wait_cv(at, ok);
        if (ok) check_latency("short_latency", at - f, 3);
        wait_trig_rise(1'b1);
    endtask

    task automatic test_back_to_back();
        int widths[4] = '{7, 64, 200, 2};
        int at;
        int f;
        bit ok;
        foreach (widths[k]) begin
            wait_trig_fall();
            repeat ($urandom_range(1, 40)) @(negedge clk);
            push_exp(widths[k], 1'b0);
            echo = 1'b1;
            repeat (widths[k]) @(negedge clk);
            echo = 1'b0;
            f = cyc;
            wait_cv(at, ok);
            if (ok) check_latency("b2b_latency", at - f, 3);
            wait_trig_rise(1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_no_echo();
        test_echo_pulse();
        test_saturation();
        test_echo_high_at_entry();
        test_reset_mid_measure();
        test_short_pulse();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes: %0d expected results never produced, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
